// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving the programcounter and datapath strobes
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             pc_we,
  output logic             jump,
  output logic             beq,
  output logic             bne,
  output logic             regorimm,
  output logic [25:0]      jumpaddress,
  output logic [15:0]      branchaddress,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic             reg_we,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             alusrc,
  output logic [2:0]       aluop,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t     st, nx;
  logic [31:0] ir;
  logic [5:0] op, fn;
  logic       is_r, is_jr, r_alu, is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw;
  logic       to_exec, imm_src;
  logic [2:0] alu_op;
  logic       pc_we_c, jump_c, beq_c, bne_c, rim_c, reg_we_c, mem_we_c;
  assign op            = ir[31:26];
  assign fn            = ir[5:0];
  assign jumpaddress   = ir[25:0];
  assign branchaddress = ir[15:0];
  assign imm           = ir[15:0];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign state         = st;
  assign is_r    = op == 6'h00;
  assign is_jr   = is_r && fn == 6'h08;
  assign r_alu   = is_r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A);
  assign is_j    = op == 6'h02;
  assign is_jal  = op == 6'h03;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_addi = op == 6'h08;
  assign is_xori = op == 6'h0E;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign to_exec = is_lw || is_sw || is_beq || is_bne || is_addi || is_xori || r_alu;
  assign imm_src = is_addi || is_xori || is_lw || is_sw;
  assign alu_op  = (is_beq || is_bne)        ? 3'd1 :
                   is_xori                   ? 3'd2 :
                   (r_alu && fn == 6'h22)    ? 3'd1 :
                   (r_alu && fn == 6'h2A)    ? 3'd3 : 3'd0;
  always_comb begin
    nx       = FETCH;
    pc_we_c  = 1'b0;
    jump_c   = 1'b0;
    beq_c    = 1'b0;
    bne_c    = 1'b0;
    rim_c    = 1'b0;
    reg_we_c = 1'b0;
    mem_we_c = 1'b0;
    regdst   = 2'd0;
    memtoreg = 2'd0;
    alusrc   = 1'b0;
    aluop    = 3'd0;
    case (st)
      FETCH: nx = DECODE;
      DECODE: begin
        if (is_j || is_jal || is_jr) begin
          pc_we_c  = 1'b1;
          jump_c   = 1'b1;
          rim_c    = is_jr;
          reg_we_c = is_jal;
          regdst   = is_jal ? 2'd2 : 2'd0;
          memtoreg = is_jal ? 2'd2 : 2'd0;
        end else if (to_exec) nx = EXEC;
        else pc_we_c = 1'b1;
      end
      EXEC: begin
        alusrc = imm_src;
        aluop  = alu_op;
        if (is_beq || is_bne) begin
          pc_we_c = 1'b1;
          beq_c   = is_beq && zero;
          bne_c   = is_bne && !zero;
        end else nx = (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        alusrc   = imm_src;
        aluop    = alu_op;
        pc_we_c  = is_sw;
        mem_we_c = is_sw;
        nx       = is_sw ? FETCH : WB;
      end
      WB: begin
        alusrc   = imm_src;
        aluop    = alu_op;
        pc_we_c  = 1'b1;
        reg_we_c = 1'b1;
        regdst   = is_r ? 2'd1 : 2'd0;
        memtoreg = is_lw ? 2'd1 : 2'd0;
      end
      default: nx = FETCH;
    endcase
  end
  // reset must suppress every side effect even mid-instruction
  assign pc_we    = pc_we_c && !reset;
  assign jump     = jump_c && !reset;
  assign beq      = beq_c && !reset;
  assign bne      = bne_c && !reset;
  assign regorimm = rim_c && !reset;
  assign reg_we   = reg_we_c && !reset;
  assign mem_we   = mem_we_c && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      st <= nx;
      if (st == FETCH) ir <= instr;
      if (pc_we) retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: per-cycle vector table with scoreboard queue plus a hand-written lw sequence
module tb_mc_control_fsm;
  logic        clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [31:0] instr = '0;
  logic        pc_we, jump, beq, bne, regorimm, reg_we, mem_we, alusrc;
  logic [25:0] jumpaddress;
  logic [15:0] branchaddress, imm;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  regdst, memtoreg;
  logic [2:0]  aluop, state;
  logic [31:0] retired;
  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .pc_we(pc_we), .jump(jump), .beq(beq),
    .bne(bne), .regorimm(regorimm), .jumpaddress(jumpaddress), .branchaddress(branchaddress),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg),
    .alusrc(alusrc), .aluop(aluop), .mem_we(mem_we), .state(state), .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [17:0] exp;
  } vec_t;
  typedef struct {
    logic [17:0] ctl;
    logic [31:0] ret;
    logic [31:0] ir;
  } sb_t;
  localparam logic [31:0] ADDI = 32'h20080005, JAL = 32'h0C000006, BEQ = 32'h1000000F,
    BNE = 32'h14000014, LW = 32'h8C090004, SW = 32'hAC090004, JR = 32'h03E00008,
    UNK = 32'hFC000000, NOPR = 32'h01095021, SUB = 32'h01095022, SLT = 32'h0109502A,
    XORI = 32'h3908000F, JUNK = 32'hFFFFFFFF;
  vec_t tbl[$];
  sb_t  sb[$];
  int   nvec = 0, nerr = 0;
  function automatic logic [17:0] f(input logic [2:0] st, input logic [6:0] stb,
                                    input logic [1:0] rdst, input logic [1:0] m2r,
                                    input logic asrc, input logic [2:0] aop);
    return {st, stb, rdst, m2r, asrc, aop};
  endfunction
  task automatic add(input logic rst, input logic [31:0] ins, input logic z, input logic [17:0] e);
    tbl.push_back('{rst, ins, z, e});
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [31:0] model_ret = '0, model_ir = '0;
  initial begin
    add(1, ADDI, 0, f(0, 0, 0, 0, 0, 0));
    add(1, ADDI, 0, f(0, 0, 0, 0, 0, 0));
    add(0, ADDI, 0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 0));
    add(0, JUNK, 0, f(4, 7'b1000010, 0, 0, 1, 0));
    add(0, JAL,  0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 7'b1100010, 2, 2, 0, 0));
    add(0, BEQ,  1, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 1, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 1, f(2, 7'b1010000, 0, 0, 0, 1));
    add(0, BEQ,  1, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 1, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 7'b1000000, 0, 0, 0, 1));
    add(0, BNE,  1, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 1, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 7'b1001000, 0, 0, 0, 1));
    add(0, BNE,  0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 1, f(2, 7'b1000000, 0, 0, 0, 1));
    add(0, LW,   0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 0));
    add(0, JUNK, 0, f(3, 0, 0, 0, 1, 0));
    add(0, JUNK, 0, f(4, 7'b1000010, 0, 1, 1, 0));
    add(0, SW,   0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 0));
    add(0, JUNK, 0, f(3, 7'b1000001, 0, 0, 1, 0));
    add(0, JR,   0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 7'b1100100, 0, 0, 0, 0));
    add(0, UNK,  0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 7'b1000000, 0, 0, 0, 0));
    add(0, NOPR, 0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 7'b1000000, 0, 0, 0, 0));
    add(0, SUB,  0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 0, 1));
    add(0, JUNK, 0, f(4, 7'b1000010, 1, 0, 0, 1));
    add(0, SLT,  0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 0, 3));
    add(0, JUNK, 0, f(4, 7'b1000010, 1, 0, 0, 3));
    add(0, XORI, 0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 2));
    add(0, JUNK, 0, f(4, 7'b1000010, 0, 0, 1, 2));
    add(0, SW,   0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 0));
    add(1, JUNK, 0, f(3, 0, 0, 0, 1, 0));
    add(0, ADDI, 0, f(0, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(1, 0, 0, 0, 0, 0));
    add(0, JUNK, 0, f(2, 0, 0, 0, 1, 0));
    add(0, JUNK, 0, f(4, 7'b1000010, 0, 0, 1, 0));
    @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      instr = tbl[i].instr;
      zero  = tbl[i].zero;
      sb.push_back('{tbl[i].exp, model_ret, model_ir});
      model_ret = tbl[i].rst ? 32'd0 : model_ret + {31'd0, tbl[i].exp[14]};
      model_ir  = tbl[i].rst ? 32'd0 : (tbl[i].exp[17:15] == 3'd0 ? tbl[i].instr : model_ir);
      #1;
      begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("ctl[%0d]", i), 64'({state, pc_we, jump, beq, bne, regorimm, reg_we, mem_we,
            regdst, memtoreg, alusrc, aluop}), 64'(e.ctl));
        chk($sformatf("retired[%0d]", i), 64'(retired), 64'(e.ret));
        chk($sformatf("irfields[%0d]", i), {jumpaddress, branchaddress, rs, rt, rd, imm},
            {e.ir[25:0], e.ir[15:0], e.ir[25:21], e.ir[20:16], e.ir[15:11], e.ir[15:0]});
      end
    end
    begin
      int cyc = 0, pulses = 0, both = 0, bad = 0;
      logic [31:0] r0;
      @(negedge clk);
      instr = LW;
      #1 r0 = retired;
      do begin
        @(negedge clk);
        instr = $urandom;
        zero  = 1'($urandom);
        #1;
        if (pc_we) pulses++;
        if (reg_we && mem_we) both++;
        if (rt != 5'd9 || imm != 16'd4) bad++;
        cyc++;
      end while (state != 3'd0 && cyc < 10);
      chk("lw_latency", 64'(cyc), 64'd5);
      chk("lw_pc_we_pulses", 64'(pulses), 64'd1);
      chk("lw_we_overlap", 64'(both), 64'd0);
      chk("lw_ir_hold", 64'(bad), 64'd0);
      chk("lw_retired", 64'(retired), 64'(r0 + 32'd1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit sitting directly downstream of the programcounter.
- Latches the instruction read from instruction memory at pcaddress into an instruction register (IR).
- Sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives the programcounter's jump/beq/bne/regorimm/jumpaddress/branchaddress inputs plus datapath strobes.
- The programcounter advances only on cycles where pc_we=1.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction memory read data for current pcaddress.
- zero  in  1  ALU zero flag (rs - rt == 0), valid in EXEC.
- pc_we  out  1  PC update strobe (one cycle per instruction).
- jump  out  1  to programcounter.
- beq  out  1  to programcounter; branch taken on equal.
- bne  out  1  to programcounter; branch taken on not-equal.
- regorimm  out  1  to programcounter; 1 = jump target from Reg_rs (jr).
- jumpaddress  out  26  IR[25:0].
- branchaddress  out  16  IR[15:0].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm  out  16  IR[15:0].
- reg_we  out  1  register file write strobe.
- regdst  out  2  0 = rt, 1 = rd, 2 = r31 (jal).
- memtoreg  out  2  0 = ALU, 1 = memory, 2 = Reg_31 link value.
- alusrc  out  1  0 = rt, 1 = sign-extended imm.
- aluop  out  3  0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT.
- mem_we  out  1  data memory write strobe.
- state  out  3  current state encoding.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are illegal and go to FETCH next cycle with all strobes 0.
- Reset (synchronous): state=FETCH, IR=0, retired=0.
  - While reset=1, pc_we, reg_we, mem_we, jump, beq, bne, regorimm are forced to 0 regardless of state.
  - Reset mid-instruction aborts it with no register or memory write.
- Strobes are combinational from state and IR; only state, IR and retired are registers.
- FETCH: IR <= instr; next DECODE. No strobes.
- DECODE, opcode decode on IR[31:26]:
  - J (0x02): jump=1, pc_we=1; next FETCH.
  - JAL (0x03): jump=1, pc_we=1, reg_we=1, regdst=2, memtoreg=2; next FETCH.
  - R-type (0x00) with funct JR (0x08): jump=1, regorimm=1, pc_we=1; next FETCH.
  - LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E, and R-type ADD 0x20 / SUB 0x22 / SLT 0x2A: next EXEC.
  - Any other opcode or funct is a NOP: pc_we=1 with jump/beq/bne=0 (PC+4); next FETCH.
- EXEC:
  - BEQ: aluop=SUB; beq=zero, pc_we=1; next FETCH. Not-taken gives PC+4.
  - BNE: aluop=SUB; bne=~zero, pc_we=1; next FETCH.
  - ADDI/LW/SW: alusrc=1, aluop=ADD. XORI: alusrc=1, aluop=XOR.
  - R-type: alusrc=0, aluop per funct.
  - LW/SW next MEM; all others next WB.
- MEM:
  - SW: mem_we=1, pc_we=1; next FETCH.
  - LW: next WB.
- WB: reg_we=1, pc_we=1; next FETCH.
  - R-type: regdst=1, memtoreg=0.
  - ADDI/XORI: regdst=0, memtoreg=0.
  - LW: regdst=0, memtoreg=1.
- Latency in cycles including FETCH: J/JAL/JR/NOP 2, BEQ/BNE 3, ALU ops and SW 4, LW 5.
- Each instruction produces exactly one pc_we pulse. reg_we and mem_we never assert in the same cycle.
- retired increments by 1 on each cycle with pc_we=1 and wraps modulo 2^CNT_W.
- IR holds its value from the FETCH posedge until the next FETCH. instr changes outside FETCH are ignored.
- zero is sampled only in EXEC for branches.

Test Plan:
- Reset held 2 cycles, then released with instr=0x20080005 (addi $8,$0,5).
  - Required: state 0→1→2→4→0.
  - In WB: reg_we=1, regdst=0, alusrc=1, aluop=0, pc_we=1.
  - retired=1 afterwards.
- instr=0x0C000006 (jal 6).
  - In DECODE: jump=1, pc_we=1, reg_we=1, regdst=2, memtoreg=2, jumpaddress=6.
  - Back in FETCH after 2 cycles.
- instr=0x1000000F (beq) with zero=1: in EXEC beq=1, branchaddress=15, pc_we=1.
  - Repeat with zero=0: beq=0, pc_we=1.
  - instr=0x14000014 (bne) with zero=0: bne=1, branchaddress=20.
- instr=0x8C090004 (lw): 5 cycles; memtoreg=1 and reg_we=1 only in WB.
  - instr=0xAC090004 (sw): mem_we=1 only in MEM, reg_we never 1.
- instr=0x03E00008 (jr $31): jump=1, regorimm=1 in DECODE.
  - instr=0xFC000000 (unknown): NOP, pc_we=1 in DECODE, no other strobe.
- Assert reset while in MEM of an sw: mem_we=0 in that cycle; state=0, retired=0 next cycle.
